// File: rtl/bus_pkg.sv
// Shared types, address map constants and decode helpers for the CPU memory bus.
// Pure package: no logic, no latency.
// Used by mem_bus and oam_dma; region_t order CART..IO matches mem_cs bits 0..4.
package bus_pkg;

  localparam int HRAM_DEPTH_DEF      = 127;
  localparam int DMA_LEN_DEF         = 160;
  localparam int DMA_START_DELAY_DEF = 1;

  localparam logic [15:0] VRAM_BASE     = 16'h8000;
  localparam logic [15:0] CART_RAM_BASE = 16'hA000;
  localparam logic [15:0] WRAM_BASE     = 16'hC000;
  localparam logic [15:0] ECHO_BASE     = 16'hE000;
  localparam logic [15:0] ECHO_LAST     = 16'hFDFF;
  localparam logic [15:0] OAM_LAST      = 16'hFE9F;
  localparam logic [15:0] IO_BASE       = 16'hFF00;
  localparam logic [15:0] ADDR_DMA      = 16'hFF46;
  localparam logic [15:0] ADDR_BOOT_OFF = 16'hFF50;
  localparam logic [15:0] HRAM_BASE     = 16'hFF80;
  localparam logic [15:0] HRAM_LAST     = 16'hFFFE;

  // Values 0..4 are external regions and index mem_cs directly.
  typedef enum logic [2:0] {
    RGN_CART   = 3'd0,
    RGN_VRAM   = 3'd1,
    RGN_WRAM   = 3'd2,
    RGN_OAM    = 3'd3,
    RGN_IO     = 3'd4,
    RGN_HRAM   = 3'd5,
    RGN_DMAREG = 3'd6,
    RGN_NONE   = 3'd7
  } region_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  function automatic region_t decode(input logic [15:0] a);
    region_t r;
    if (a < VRAM_BASE)          r = RGN_CART;
    else if (a < CART_RAM_BASE) r = RGN_VRAM;
    else if (a < WRAM_BASE)     r = RGN_CART;
    else if (a <= ECHO_LAST)    r = RGN_WRAM;
    else if (a <= OAM_LAST)     r = RGN_OAM;
    else if (a < IO_BASE)       r = RGN_NONE;
    else if (a == ADDR_DMA)     r = RGN_DMAREG;
    else if (a < HRAM_BASE)     r = RGN_IO;
    else if (a <= HRAM_LAST)    r = RGN_HRAM;
    else                        r = RGN_IO;
    return r;
  endfunction

  function automatic logic is_ext(input region_t r);
    return (r == RGN_CART) || (r == RGN_VRAM) || (r == RGN_WRAM) ||
           (r == RGN_OAM)  || (r == RGN_IO);
  endfunction

  function automatic logic [4:0] cs_of(input region_t r);
    logic [4:0] cs;
    case (r)
      RGN_CART: cs = 5'b00001;
      RGN_VRAM: cs = 5'b00010;
      RGN_WRAM: cs = 5'b00100;
      RGN_OAM:  cs = 5'b01000;
      RGN_IO:   cs = 5'b10000;
      default:  cs = 5'b00000;
    endcase
    return cs;
  endfunction

  // Echo RAM E000..FDFF aliases C000..DDFF: clear bit13 only inside that window,
  // so FExx/FFxx addresses (OAM, IO) are never folded down.
  function automatic logic [15:0] bus_addr(input logic [15:0] a);
    logic [15:0] b;
    b = a;
    if (a >= ECHO_BASE && a <= ECHO_LAST) b[13] = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/mem_bus_oam_dma.sv
// OAM DMA engine: FF46 write -> START delay -> DMA_LEN byte copies into OAM.
// Latency: first byte DMA_START_DELAY+1 cycles after the FF46 write edge, one byte per clock.
// No backpressure: sources are asynchronous and OAM accepts every cycle; o_lock marks bus ownership.
module oam_dma
  import bus_pkg::*;
#(
  parameter int DMA_LEN         = DMA_LEN_DEF,
  parameter int DMA_START_DELAY = DMA_START_DELAY_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_start_hi,
  input  logic [7:0]  i_src_rdata,
  output logic [15:0] o_dma_addr,
  output logic [7:0]  o_src_hi,
  output logic        o_lock,
  output logic        o_active,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_wdata,
  output logic        o_oam_we
);

  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(DMA_START_DELAY - 1);

  dma_state_t r_state, w_state_nxt;
  logic [7:0] r_idx, w_idx_nxt;
  logic [7:0] r_dly, w_dly_nxt;
  logic [7:0] r_src_hi, w_src_hi_nxt;
  logic       w_xfer;

  // State, index, delay counter and FF46 source register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= DMA_IDLE;
      r_idx    <= 8'h00;
      r_dly    <= 8'h00;
      r_src_hi <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_dly    <= w_dly_nxt;
      r_src_hi <= w_src_hi_nxt;
    end
  end

  // Next state: a start outside XFER (re)arms the delay; XFER saturates at the last index.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_dly_nxt    = r_dly;
    w_src_hi_nxt = r_src_hi;
    if (i_start && (r_state != DMA_XFER)) begin
      w_src_hi_nxt = i_start_hi;
      w_state_nxt  = DMA_START;
      w_dly_nxt    = 8'h00;
      w_idx_nxt    = 8'h00;
    end else begin
      case (r_state)
        DMA_START: begin
          if (r_dly == DLY_LAST) begin
            w_state_nxt = DMA_XFER;
            w_idx_nxt   = 8'h00;
          end else begin
            w_dly_nxt = r_dly + 8'h01;
          end
        end
        DMA_XFER: begin
          if (r_idx == IDX_LAST) w_state_nxt = DMA_IDLE;
          else                   w_idx_nxt   = r_idx + 8'h01;
        end
        default: ;
      endcase
    end
  end

  assign w_xfer      = (r_state == DMA_XFER);
  assign o_dma_addr  = {r_src_hi, r_idx};
  assign o_src_hi    = r_src_hi;
  assign o_lock      = w_xfer;
  assign o_active    = (r_state != DMA_IDLE);
  assign o_oam_we    = w_xfer;
  assign o_oam_addr  = w_xfer ? r_idx : 8'h00;
  assign o_oam_wdata = w_xfer ? i_src_rdata : 8'h00;

endmodule

// File: rtl/mem_bus.sv
// CPU memory-map decoder, HRAM and OAM DMA owner; optional boot ROM overlay under MEM_BUS_BOOTROM_EN.
// Latency: reads combinational (same cycle), writes take effect at the next clk edge.
// No backpressure: during DMA XFER the CPU sees FF / dropped writes everywhere except HRAM.
module mem_bus
  import bus_pkg::*;
#(
  parameter int HRAM_DEPTH      = HRAM_DEPTH_DEF,
  parameter int DMA_LEN         = DMA_LEN_DEF,
  parameter int DMA_START_DELAY = DMA_START_DELAY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [4:0]  mem_cs,
  input  logic [7:0]  cart_rdata,
  input  logic [7:0]  vram_rdata,
  input  logic [7:0]  wram_rdata,
  input  logic [7:0]  oam_rdata,
  input  logic [7:0]  io_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
`ifdef MEM_BUS_BOOTROM_EN
  ,
  input  logic [7:0]  boot_rdata,
  output logic        boot_active
`endif
);

  localparam int HW = $clog2(HRAM_DEPTH);

  logic [7:0]  r_hram [0:HRAM_DEPTH-1];
  region_t     w_cpu_rgn, w_dma_rgn;
  logic        w_dma_lock, w_cpu_own, w_rd, w_wr, w_cpu_ext;
  logic        w_ff46_wr, w_hram_wr, w_boot_rd, w_boot_wr;
  logic [7:0]  w_boot_dat, w_dma_src_hi, w_dma_rdata;
  logic [15:0] w_dma_addr;

  assign w_cpu_rgn = decode(cpu_addr);
  assign w_dma_rgn = decode(w_dma_addr);
  // While DMA copies, the CPU only keeps HRAM; simultaneous rd+wr is treated as a write.
  assign w_cpu_own = !w_dma_lock || (w_cpu_rgn == RGN_HRAM);
  assign w_rd      = cpu_rd_en && !cpu_wr_en && w_cpu_own;
  assign w_wr      = cpu_wr_en && w_cpu_own;
  assign w_ff46_wr = w_wr && (w_cpu_rgn == RGN_DMAREG);
  assign w_hram_wr = w_wr && (w_cpu_rgn == RGN_HRAM);
  assign w_cpu_ext = (w_rd || w_wr) && is_ext(w_cpu_rgn) && !w_boot_rd && !w_boot_wr;

`ifdef MEM_BUS_BOOTROM_EN
  logic r_boot_active;

  assign w_boot_rd   = r_boot_active && w_rd && (cpu_addr[15:8] == 8'h00);
  assign w_boot_wr   = w_wr && (cpu_addr == ADDR_BOOT_OFF);
  assign w_boot_dat  = boot_rdata;
  assign boot_active = r_boot_active;

  // Overlay stays off until reset once any nonzero value is written to FF50.
  always_ff @(posedge clk) begin
    if (rst)                                 r_boot_active <= 1'b1;
    else if (w_boot_wr && (cpu_wdata != 0))  r_boot_active <= 1'b0;
  end
`else
  assign w_boot_rd  = 1'b0;
  assign w_boot_wr  = 1'b0;
  assign w_boot_dat = 8'hFF;
`endif

  // HRAM: contents survive reset, so only the write port is clocked.
  always_ff @(posedge clk) begin
    if (w_hram_wr) r_hram[cpu_addr[HW-1:0]] <= cpu_wdata;
  end

  oam_dma #(
    .DMA_LEN         (DMA_LEN),
    .DMA_START_DELAY (DMA_START_DELAY)
  ) u_dma (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (w_ff46_wr),
    .i_start_hi  (cpu_wdata),
    .i_src_rdata (w_dma_rdata),
    .o_dma_addr  (w_dma_addr),
    .o_src_hi    (w_dma_src_hi),
    .o_lock      (w_dma_lock),
    .o_active    (dma_active),
    .o_oam_addr  (oam_addr),
    .o_oam_wdata (oam_wdata),
    .o_oam_we    (oam_we)
  );

  // CPU read data; FF for no access, write cycles, locked-out regions and unmapped space.
  always_comb begin
    cpu_rdata = 8'hFF;
    if (w_rd) begin
      case (w_cpu_rgn)
        RGN_CART:   cpu_rdata = cart_rdata;
        RGN_VRAM:   cpu_rdata = vram_rdata;
        RGN_WRAM:   cpu_rdata = wram_rdata;
        RGN_OAM:    cpu_rdata = oam_rdata;
        RGN_IO:     cpu_rdata = io_rdata;
        RGN_HRAM:   cpu_rdata = r_hram[cpu_addr[HW-1:0]];
        RGN_DMAREG: cpu_rdata = w_dma_src_hi;
        default:    cpu_rdata = 8'hFF;
      endcase
    end
    if (w_boot_rd) cpu_rdata = w_boot_dat;
  end

  // DMA source byte; OAM cannot feed itself, so it reads FF like unmapped space.
  always_comb begin
    w_dma_rdata = 8'hFF;
    case (w_dma_rgn)
      RGN_CART:   w_dma_rdata = cart_rdata;
      RGN_VRAM:   w_dma_rdata = vram_rdata;
      RGN_WRAM:   w_dma_rdata = wram_rdata;
      RGN_IO:     w_dma_rdata = io_rdata;
      RGN_HRAM:   w_dma_rdata = r_hram[w_dma_addr[HW-1:0]];
      RGN_DMAREG: w_dma_rdata = w_dma_src_hi;
      default:    w_dma_rdata = 8'hFF;
    endcase
  end

  // Shared bus: DMA owns it during XFER, otherwise only external CPU accesses drive it.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_cs    = 5'b00000;
    if (w_dma_lock) begin
      mem_addr = bus_addr(w_dma_addr);
      mem_rd   = 1'b1;
      if (w_dma_rgn != RGN_OAM) mem_cs = cs_of(w_dma_rgn);
    end else if (w_cpu_ext) begin
      mem_addr  = bus_addr(cpu_addr);
      mem_rd    = w_rd;
      mem_wr    = w_wr;
      mem_wdata = w_wr ? cpu_wdata : 8'h00;
      mem_cs    = cs_of(w_cpu_rgn);
    end
  end

endmodule

// File: tb/tb_mem_bus.sv
// Directed bench for mem_bus: expectations queued at issue time, checked by a negedge monitor.
// Runs a few hundred cycles per DMA; a watchdog bounds the run.
// Boot ROM checks are compiled in when MEM_BUS_BOOTROM_EN is defined.
module tb_mem_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en, cpu_wr_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_wr;
  logic [4:0]  mem_cs;
  logic [7:0]  cart_rdata, vram_rdata, wram_rdata, oam_rdata, io_rdata;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we, dma_active;
`ifdef MEM_BUS_BOOTROM_EN
  logic [7:0]  boot_rdata;
  logic        boot_active;
  assign boot_rdata = 8'hB0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Device models: fixed per-region bytes, WRAM backed by a preloaded array.
  logic [7:0] wram [0:8191];
  assign cart_rdata = 8'hCA;
  assign vram_rdata = 8'h7A;
  assign oam_rdata  = 8'h0A;
  assign io_rdata   = 8'h10;
  assign wram_rdata = wram[mem_addr[12:0]];

  mem_bus dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_cs(mem_cs),
    .cart_rdata(cart_rdata), .vram_rdata(vram_rdata), .wram_rdata(wram_rdata),
    .oam_rdata(oam_rdata), .io_rdata(io_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .dma_active(dma_active)
`ifdef MEM_BUS_BOOTROM_EN
    , .boot_rdata(boot_rdata), .boot_active(boot_active)
`endif
  );

  localparam int S_RDATA = 0, S_CS = 1, S_ADDR = 2, S_WR = 3, S_ACT = 4, S_WE = 5,
                 S_RD = 6, S_OADDR = 7, S_ODATA = 8, S_OAMQ = 10, S_C2 = 11;

  typedef struct { int cyc; string nm; int sel; logic [15:0] val; } chk_t;
  typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } oam_t;
  chk_t chk_q[$];
  oam_t oam_q[$];
  int   n_chk = 0, n_fail = 0, c2_reads = 0;
  bit   watch_c2 = 1'b0;

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      S_RDATA: return {8'h00, cpu_rdata};
      S_CS:    return {11'h000, mem_cs};
      S_ADDR:  return mem_addr;
      S_WR:    return {15'h0000, mem_wr};
      S_ACT:   return {15'h0000, dma_active};
      S_WE:    return {15'h0000, oam_we};
      S_RD:    return {15'h0000, mem_rd};
      S_OADDR: return {8'h00, oam_addr};
      S_ODATA: return {8'h00, oam_wdata};
      S_OAMQ:  return 16'(oam_q.size());
      S_C2:    return 16'(c2_reads);
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic expect_(input string nm, input int sel, input logic [15:0] val);
    chk_t e;
    e.cyc = cyc; e.nm = nm; e.sel = sel; e.val = val;
    chk_q.push_back(e);
  endtask

  task automatic push_oam(input int c, input logic [7:0] a, input logic [7:0] d);
    oam_t o;
    o.cyc = c; o.a = a; o.d = d;
    oam_q.push_back(o);
  endtask

  // Monitor: pops cycle-stamped expectations and every OAM write the DUT presents.
  always @(negedge clk) begin
    chk_t e;
    oam_t o;
    logic [15:0] got;
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      e = chk_q.pop_front();
      got = pick(e.sel);
      n_chk++;
      if (e.cyc != cyc || got !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)", e.nm, got, e.val, cyc, e.cyc);
      end
    end
    if (oam_we === 1'b1) begin
      n_chk++;
      if (oam_q.size() == 0) begin
        n_fail++;
        $display("FAIL oam_unexpected: got addr %h data %h at cycle %0d, expected no write", oam_addr, oam_wdata, cyc);
      end else begin
        o = oam_q.pop_front();
        if (o.cyc != cyc || o.a !== oam_addr || o.d !== oam_wdata) begin
          n_fail++;
          $display("FAIL oam_write: got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                   cyc, oam_addr, oam_wdata, o.cyc, o.a, o.d);
        end
      end
    end
    if (watch_c2 && mem_rd && (mem_addr[15:8] == 8'hC2 || mem_addr[15:8] == 8'hE2)) c2_reads++;
  end

  task automatic step();
    @(posedge clk); #1;
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic rd(input logic [15:0] a);
    cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = a;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b1; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step();
  endtask

  logic [15:0] sw_a  [10] = '{16'h0100, 16'h8000, 16'hA000, 16'hC000, 16'hE123,
                              16'hFE00, 16'hFEA0, 16'hFF40, 16'hFF90, 16'hFFFF};
  logic [7:0]  sw_d  [10] = '{8'hCA, 8'h7A, 8'hCA, 8'h77, 8'h1F, 8'h0A, 8'hFF, 8'h10, 8'h00, 8'h10};
  bit          sw_dc [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
  logic [4:0]  sw_cs [10] = '{5'h01, 5'h02, 5'h01, 5'h04, 5'h04, 5'h08, 5'h00, 5'h10, 5'h00, 5'h10};
  logic [15:0] sw_ma [10] = '{16'h0100, 16'h8000, 16'hA000, 16'hC000, 16'hC123,
                              16'hFE00, 16'h0000, 16'hFF40, 16'h0000, 16'hFFFF};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int w, s, u, r;
    for (int i = 0; i < 8192; i++) wram[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      wram[13'h100 + 13'(i)] = 8'(i) ^ 8'h3C;
      wram[13'h200 + 13'(i)] = 8'(i) + 8'h01;
      wram[13'h300 + 13'(i)] = 8'(i) ^ 8'h5A;
    end
    wram[0] = 8'h77;

    rst = 1'b1; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    expect_("rst_act", S_ACT, 16'h0); expect_("rst_we", S_WE, 16'h0);
    expect_("rst_cs", S_CS, 16'h0);   expect_("rst_rd", S_RD, 16'h0);
    expect_("rst_wr", S_WR, 16'h0);   expect_("rst_idle_rdata", S_RDATA, 16'h00FF);
    expect_("rst_oaddr", S_OADDR, 16'h0); expect_("rst_odata", S_ODATA, 16'h0);
    step();
    rd(16'hFF46); expect_("rst_ff46", S_RDATA, 16'h0000); expect_("ff46_cs", S_CS, 16'h0); step();

`ifdef MEM_BUS_BOOTROM_EN
    rd(16'h0000); expect_("boot_rd", S_RDATA, 16'h00B0); expect_("boot_cs", S_CS, 16'h0); step();
    wr(16'hFF50, 8'h01); expect_("ff50_wr", S_WR, 16'h0); expect_("ff50_cs", S_CS, 16'h0); step();
    rd(16'h0000); expect_("boot_off_rd", S_RDATA, 16'h00CA); expect_("boot_off_cs", S_CS, 16'h01); step();
`endif

    for (int i = 0; i < 10; i++) begin
      rd(sw_a[i]);
      if (sw_dc[i]) expect_($sformatf("dec_%h_d", sw_a[i]), S_RDATA, {8'h00, sw_d[i]});
      expect_($sformatf("dec_%h_cs", sw_a[i]), S_CS, {11'h0, sw_cs[i]});
      if (sw_cs[i] != 0) expect_($sformatf("dec_%h_a", sw_a[i]), S_ADDR, sw_ma[i]);
      step();
    end

    wr(16'hFF80, 8'h5A); expect_("hram_w0_cs", S_CS, 16'h0); expect_("hram_w0_wr", S_WR, 16'h0); step();
    wr(16'hFFFE, 8'hA5); expect_("hram_w1_cs", S_CS, 16'h0); step();
    rd(16'hFF80); expect_("hram_r0", S_RDATA, 16'h005A); expect_("hram_r0_cs", S_CS, 16'h0); step();
    rd(16'hFFFE); expect_("hram_r1", S_RDATA, 16'h00A5); expect_("hram_r1_cs", S_CS, 16'h0); step();

    cpu_rd_en = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 16'hFF81; cpu_wdata = 8'h11;
    expect_("both_hram_rdata", S_RDATA, 16'h00FF); step();
    rd(16'hFF81); expect_("both_hram_wrote", S_RDATA, 16'h0011); step();
    cpu_rd_en = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 16'hC000; cpu_wdata = 8'h55;
    expect_("both_ext_rdata", S_RDATA, 16'h00FF); expect_("both_ext_wr", S_WR, 16'h1);
    expect_("both_ext_rd", S_RD, 16'h0); expect_("both_ext_cs", S_CS, 16'h04); step();
    wr(16'hFEA0, 8'h12); expect_("unmapped_wr", S_WR, 16'h0); expect_("unmapped_cs", S_CS, 16'h0); step();

    // DMA from C100 with lock probes while copying.
    w = cyc;
    wr(16'hFF46, 8'hC1); expect_("c1_wr_cs", S_CS, 16'h0); expect_("c1_pre_act", S_ACT, 16'h0);
    for (int i = 0; i < 160; i++) push_oam(w + 2 + i, 8'(i), 8'(i) ^ 8'h3C);
    step();
    expect_("c1_start_act", S_ACT, 16'h1); expect_("c1_start_we", S_WE, 16'h0); step();
    expect_("c1_x0_addr", S_ADDR, 16'hC100); expect_("c1_x0_rd", S_RD, 16'h1);
    expect_("c1_x0_cs", S_CS, 16'h04); step();
    idle_until(w + 10);
    rd(16'hC000); expect_("lock_rd", S_RDATA, 16'h00FF); expect_("lock_rd_addr", S_ADDR, 16'hC108); step();
    wr(16'h8000, 8'h77); expect_("lock_wr", S_WR, 16'h0); expect_("lock_wr_addr", S_ADDR, 16'hC109); step();
    wr(16'hFF85, 8'h99); step();
    rd(16'hFF85); expect_("lock_hram", S_RDATA, 16'h0099); step();
    wr(16'hFF46, 8'h00); step();
    idle_until(w + 161);
    expect_("c1_last_act", S_ACT, 16'h1); expect_("c1_last_oaddr", S_OADDR, 16'h009F); step();
    expect_("c1_done_act", S_ACT, 16'h0); expect_("c1_done_we", S_WE, 16'h0); step();
    rd(16'hFF46); expect_("c1_ff46", S_RDATA, 16'h00C1); step();
    step(); expect_("c1_oam_drained", S_OAMQ, 16'h0); step();

    // Restart in START: E2 is replaced by C3 before any transfer.
    s = cyc;
    wr(16'hFF46, 8'hE2); watch_c2 = 1'b1; step();
    wr(16'hFF46, 8'hC3); expect_("rs_start_act", S_ACT, 16'h1); expect_("rs_start_we", S_WE, 16'h0);
    for (int i = 0; i < 160; i++) push_oam(s + 3 + i, 8'(i), 8'(i) ^ 8'h5A);
    step();
    expect_("rs_delay_we", S_WE, 16'h0); step();
    expect_("rs_x0_addr", S_ADDR, 16'hC300); step();
    idle_until(s + 163);
    expect_("rs_done_act", S_ACT, 16'h0); watch_c2 = 1'b0; step();
    expect_("rs_no_c2_reads", S_C2, 16'h0); expect_("rs_oam_drained", S_OAMQ, 16'h0);
    rd(16'hFF46); expect_("rs_ff46", S_RDATA, 16'h00C3); step();

    // Echo source E2 reads WRAM at C2xx.
    u = cyc;
    wr(16'hFF46, 8'hE2);
    for (int i = 0; i < 160; i++) push_oam(u + 2 + i, 8'(i), 8'(i) + 8'h01);
    step();
    idle_until(u + 2);
    expect_("echo_x0_addr", S_ADDR, 16'hC200); expect_("echo_x0_cs", S_CS, 16'h04);
    expect_("echo_x0_rd", S_RD, 16'h1); step();
    idle_until(u + 162);
    expect_("echo_done_act", S_ACT, 16'h0); expect_("echo_oam_drained", S_OAMQ, 16'h0);
    rd(16'hFF46); expect_("echo_ff46", S_RDATA, 16'h00E2); step();

    // Reset while copying index 50.
    r = cyc;
    wr(16'hFF46, 8'hC1);
    for (int i = 0; i <= 50; i++) push_oam(r + 2 + i, 8'(i), 8'(i) ^ 8'h3C);
    step();
    idle_until(r + 52);
    rst = 1'b1; expect_("rstm_we_idx50", S_WE, 16'h1); expect_("rstm_oaddr", S_OADDR, 16'h0032); step();
    rst = 1'b0; expect_("rstm_act", S_ACT, 16'h0); expect_("rstm_we", S_WE, 16'h0); step();
    rd(16'hFF46); expect_("rstm_ff46", S_RDATA, 16'h0000); expect_("rstm_act2", S_ACT, 16'h0); step();
    repeat (3) step();
    expect_("rstm_oam_drained", S_OAMQ, 16'h0); step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + chk_q.size());
    $finish;
  end

endmodule
